seq_approx_mul: RTL and testbench

- Parametrised, iterative successor to the 8x8 four-quadrant multiplier.
- Splits WIDTH-bit unsigned operands into D = WIDTH/SUB digits of SUB bits each.
- Computes one SUBxSUB sub-product per cycle on a single shared sub-multiplier and shift-accumulates it.
- Per-transaction approximate mode skips low-significance sub-products, trading accuracy for fewer cycles.
- Valid/ready on both sides; drops into the approximate-multiplier evaluation datapaths.

---
 rtl/seq_approx_mul.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_approx_mul.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_approx_mul.sv
// -----------------------------------------------------------------------------
// seq_approx_mul
//
// Iterative unsigned WIDTH x WIDTH multiplier. Operands are split into
// D = WIDTH/SUB digits and one SUB x SUB digit product is formed per cycle
// on a single shared sub-multiplier, then shifted into a 2*WIDTH accumulator.
// Digit pairs are walked with the a-digit index i outer and the b-digit index
// j inner, both ascending.
//
// Approximate mode (approx = 1, sampled with the operands) skips every pair
// with i + j < DROP_COLS. Skipped pairs cost no cycle, so the result is the
// exact product minus the skipped terms and arrives earlier.
//
// Optional feature (macro SEQ_APPROX_MUL_ZERO_BYPASS_EN):
//   when defined, a zero operand at accept skips the pair walk and the block
//   presents prod = 0 one cycle after the accept edge. When undefined, zero
//   operands take the full walk and still produce 0.
//
// Parameters:
//   WIDTH      operand width; multiple of SUB and at least 2*SUB
//   SUB        digit width of the shared sub-multiplier
//   DROP_COLS  approximate mode drops pairs with i + j < DROP_COLS (0..2*D-1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       unsigned operands
//   approx     1 = approximate mode, 0 = accurate mode
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   prod       2*WIDTH product, held until the result handshake
//   busy       high in CALC or DONE
// -----------------------------------------------------------------------------
module seq_approx_mul #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned SUB       = 4,
   parameter int unsigned DROP_COLS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               approx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               busy
);

   localparam int unsigned D  = WIDTH / SUB;
   localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned PW = 2 * WIDTH;

   // First non-skipped pair in approximate mode. Row r starts at
   // j = max(0, DROP_COLS - r); the first usable row is the first one whose
   // start column still lies inside the row.
   localparam int unsigned FIRST_I  = (DROP_COLS > D - 1) ? DROP_COLS - (D - 1) : 0;
   localparam int unsigned FIRST_J  = (DROP_COLS > FIRST_I) ? DROP_COLS - FIRST_I : 0;
   // Every pair is dropped: the walk collapses to a zero result.
   localparam bit          ALL_SKIP = (DROP_COLS > 2 * D - 2);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             approx_q;
   logic             short_q;
   logic [PW-1:0]    acc_q;
   logic [IW-1:0]    i_q;
   logic [IW-1:0]    j_q;

   // ---------------------------------------------------------------------------
   // Datapath: current digit pair, shared sub-multiplier, aligned term
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [SUB-1:0]   a_dig;
   logic [SUB-1:0]   b_dig;
   logic [2*SUB-1:0] sub_prod;
   logic [IW:0]      col;
   logic [PW-1:0]    term;
   logic [PW-1:0]    acc_sum;

   assign a_shift  = a_q >> (i_q * SUB);
   assign b_shift  = b_q >> (j_q * SUB);
   assign a_dig    = a_shift[SUB-1:0];
   assign b_dig    = b_shift[SUB-1:0];
   assign sub_prod = {{SUB{1'b0}}, a_dig} * {{SUB{1'b0}}, b_dig};
   // Extra bit so i + j cannot wrap for the column weight.
   assign col      = {1'b0, i_q} + {1'b0, j_q};
   assign term     = {{(PW - 2 * SUB){1'b0}}, sub_prod} << (col * SUB);
   assign acc_sum  = acc_q + term;

   // ---------------------------------------------------------------------------
   // Pair walk: next pair after the current one, and the start pair at accept
   // ---------------------------------------------------------------------------
   logic          last_pair;
   logic [IW-1:0] next_i;
   logic [IW-1:0] next_j;
   logic [31:0]   next_row;

   // Within a row, once a pair is kept every later pair in that row is kept,
   // and the following row always has a kept pair, so only the row start
   // column needs adjusting for approximate mode.
   always_comb begin
      last_pair = (i_q == IW'(D - 1)) && (j_q == IW'(D - 1));
      next_row  = 32'(i_q) + 32'd1;
      next_i    = i_q;
      next_j    = j_q + 1'b1;
      if (j_q == IW'(D - 1)) begin
         next_i = i_q + 1'b1;
         next_j = '0;
         if (approx_q && (DROP_COLS > next_row)) begin
            next_j = IW'(DROP_COLS - next_row);
         end
      end
   end

   logic [IW-1:0] start_i;
   logic [IW-1:0] start_j;

   always_comb begin
      start_i = '0;
      start_j = '0;
      if (approx) begin
         start_i = IW'(FIRST_I);
         start_j = IW'(FIRST_J);
      end
   end

   // Operand pairs whose result is known to be zero without walking digits.
   logic zero_ops;
   logic skip_walk;

`ifdef SEQ_APPROX_MUL_ZERO_BYPASS_EN
   assign zero_ops = (a == '0) || (b == '0);
`else
   assign zero_ops = 1'b0;
`endif

   assign skip_walk = zero_ops || (approx && ALL_SKIP);

   // ---------------------------------------------------------------------------
   // Control FSM with registered handshake outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         prod      <= '0;
         acc_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         approx_q  <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  approx_q <= approx;
                  short_q  <= skip_walk;
                  acc_q    <= '0;
                  i_q      <= start_i;
                  j_q      <= start_j;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= StCalc;
               end
            end

            StCalc: begin
               if (short_q) begin
                  // Known-zero result: one pass through CALC, no digit products.
                  prod      <= '0;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  acc_q <= acc_sum;
                  if (last_pair) begin
                     prod      <= acc_sum;
                     out_valid <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     i_q <= next_i;
                     j_q <= next_j;
                  end
               end
            end

            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  i_q       <= '0;
                  j_q       <= '0;
                  state_q   <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_approx_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_approx_mul
//
// Scoreboard bench for seq_approx_mul with default parameters
// (WIDTH = 16, SUB = 4, DROP_COLS = 2). The driver pushes the hand-computed
// product and latency for each accepted operand pair; an independent monitor
// pops and compares when out_valid rises, and checks hold/handshake behaviour.
// -----------------------------------------------------------------------------
module tb_seq_approx_mul;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        approx;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] prod;
   logic        busy;

   always #5 clk = ~clk;

   seq_approx_mul #(
      .WIDTH     (16),
      .SUB       (4),
      .DROP_COLS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx    (approx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] exp;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

`ifdef SEQ_APPROX_MUL_ZERO_BYPASS_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 16;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: capture handshake inputs at the edge, judge outputs 1 ns later.
   logic v_edge;
   logic r_edge;
   logic rst_edge;

   always @(posedge clk) begin
      v_edge   = out_valid;
      r_edge   = out_ready;
      rst_edge = rst_n;
      #1;
      if (rst_edge) begin
         if (v_edge && r_edge) begin
            check("post_hs_out_valid", 32'(out_valid), 32'd0);
            check("post_hs_in_ready", 32'(in_ready), 32'd1);
         end else if (v_edge) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_prod", prod, cur.exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
         end else if (out_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got prod 0x%0h, expected no output", prod);
            end else begin
               cur = sb_q.pop_front();
               check("prod", prod, cur.exp);
               check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            end
         end
      end
   end

   task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tapx,
                        input logic [31:0] texp, input int tlat);
      int guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got in_ready 0, expected 1 within 200 cycles");
         return;
      end
      a        = ta;
      b        = tb_v;
      approx   = tapx;
      in_valid = 1'b1;
      e.exp    = texp;
      e.lat    = tlat;
      e.acc    = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      // Scrambled inputs while busy must be ignored.
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb_v;
      approx   = ~tapx;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((sb_q.size() != 0 || out_valid) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0 || out_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", sb_q.size());
      end
   endtask

   initial begin
      int guard;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      approx    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_prod", prod, 32'd0);
      rst_n = 1'b1;

      // Directed vectors: accurate and approximate.
      issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16); drain();
      issue(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFDE300, 13); drain();
      issue(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 16); drain();
      issue(16'h00FF, 16'h0101, 1'b1, 32'h0000FF00, 13); drain();
      issue(16'h1234, 16'h5678, 1'b0, 32'h06260060, 16); drain();
      issue(16'h1234, 16'h5678, 1'b1, 32'h0625FD00, 13); drain();
      // Only the dropped (0,0) pair is non-zero.
      issue(16'h0003, 16'h0005, 1'b1, 32'h00000000, 13); drain();

      // Back-pressure: hold out_ready low for 5 cycles after out_valid.
      out_ready = 1'b0;
      issue(16'h8001, 16'h0002, 1'b0, 32'h00010002, 16);
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL bp_timeout: got out_valid 0, expected 1");
      end
      repeat (5) @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Reset in the middle of CALC discards the operation.
      issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_prod", prod, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      issue(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 16); drain();

      // Zero operand.
      issue(16'h0000, 16'h1234, 1'b0, 32'h00000000, ZERO_LAT); drain();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish before 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
